xidoo_input_cond: RTL and testbench
===================================

Name: xidoo_input_cond

Overview:
Front-end conditioner sitting directly upstream of the processor core's SWT/Enter inputs. It synchronises and debounces the raw 8-bit switch bank and the raw Enter push-button. It delivers a glitch-free switch byte and a debounced Enter level plus a one-cycle press strobe. The switch byte is frozen while a press is being qualified or held, so the core always reads a coherent value on Enter.

Parameters:
DEB_CYCLES, 50000, stable-input qualification time in CLK cycles (1 ms at 50 MHz); legal range 2..65535.

Ports:
CLK  input  1  master clock; all logic on rising edge
RST  input  1  master reset, asynchronous, active-low
SW_RAW  input  8  raw switch bank, asynchronous to CLK
BTN_RAW  input  1  raw Enter button, active-high, asynchronous, bouncing
SWT  output  8  debounced switch byte to core SWT
Enter  output  1  debounced Enter level to core Enter
ENTER_PULSE  output  1  one-cycle strobe on each qualified press

Behaviour:
- Reset (RST=0, asynchronous): SWT=0x00, Enter=0, ENTER_PULSE=0.
- Reset also clears all synchroniser flops, the switch candidate and both counters, and sets the FSM to IDLE.
- Reset asserted mid-operation aborts any qualification. After RST deasserts, the block restarts from IDLE with nothing pending.
- Synchronisers: 2-flop chain on each of the 9 raw bits. Outputs are sw_s[7:0] and btn_s. Nothing downstream samples raw inputs.
- Switch debounce:
  - sw_cand[7:0] and sw_cnt (16 b). If sw_s != sw_cand, then sw_cand <= sw_s and sw_cnt <= 0.
  - Otherwise sw_cnt increments, saturating at DEB_CYCLES-1.
  - SWT <= sw_cand on any edge where sw_s == sw_cand, sw_cnt == DEB_CYCLES-1, and the FSM is IDLE (freeze rule).
- Latency: edge 1 is the first rising edge sampling the new stable raw value. SWT updates on edge DEB_CYCLES+3 (edge 7 for DEB_CYCLES=4).
- Any raw change before that point restarts qualification. No intermediate value ever reaches SWT.
- Button FSM (states IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT; one shared 16-b btn_cnt):
  - IDLE: btn_s=1 -> PRESS_WAIT, btn_cnt<=0.
  - PRESS_WAIT: btn_s=0 -> IDLE (bounce rejected). Else if btn_cnt==DEB_CYCLES-1 -> PRESSED, Enter<=1, ENTER_PULSE<=1. Else btn_cnt++.
  - PRESSED: ENTER_PULSE<=0. btn_s=0 -> RELEASE_WAIT, btn_cnt<=0.
  - RELEASE_WAIT: btn_s=1 -> PRESSED (release bounce; Enter stays 1, no new pulse). Else if btn_cnt==DEB_CYCLES-1 -> IDLE, Enter<=0. Else btn_cnt++.
- Enter timing: rises on edge DEB_CYCLES+3 after a clean press. Falls on edge DEB_CYCLES+3 after a clean release.
- ENTER_PULSE is high for exactly one cycle, coincident with the first Enter=1 cycle.
- Freeze rule:
  - While the FSM is not IDLE, SWT holds. Candidate tracking and sw_cnt keep running.
  - A switch value that qualified during the freeze is already saturated. It is applied on the first edge on which the FSM is IDLE, i.e. one edge after Enter falls.
- Simultaneous events: a switch qualification on the same edge as IDLE->PRESS_WAIT still updates SWT, because the FSM is IDLE on that edge. On any later edge it is deferred.
- Counters never wrap. Both saturate or reset as stated above.

Test Plan:
(All with DEB_CYCLES=4.)
1. Reset: drive RST=0 mid press-qualification with SWT=0x5A -> SWT=0x00, Enter=0, ENTER_PULSE=0 immediately, without a clock edge. After release, press qualification restarts from IDLE.
2. SW_RAW 0x00->0xA5 held stable -> SWT=0x00 through edge 6, SWT=0xA5 from edge 7.
3. Switch bounce: SW_RAW alternates 0x0F/0xF0 every 2 cycles for 12 cycles, then settles at 0x3C -> SWT never takes 0x0F or 0xF0, and becomes 0x3C on edge 7 after the last change.
4. Clean press: BTN_RAW=1 for 20 cycles, then 0 -> Enter rises edge 7 with ENTER_PULSE=1 for exactly one cycle. Enter falls edge 7 after release, and no second pulse occurs.
5. Glitches:
   - BTN_RAW=1 for 2 cycles only -> Enter and ENTER_PULSE stay 0.
   - While PRESSED, BTN_RAW=0 for 2 cycles -> Enter stays 1 and no extra pulse occurs.
6. Freeze: SWT=0x11; press and qualify; while Enter=1, set SW_RAW=0x22 for 10 cycles -> SWT stays 0x11 throughout. Release; SWT=0x22 one edge after Enter falls.

Source files
------------

// File: rtl/xidoo_input_cond_if.sv
// Raw switch/button inputs and conditioned outputs between the board front-end and the core.
interface xidoo_input_cond_if;
  logic [7:0] SW_RAW;
  logic       BTN_RAW;
  logic [7:0] SWT;
  logic       Enter;
  logic       ENTER_PULSE;

  modport master (output SW_RAW, BTN_RAW, input SWT, Enter, ENTER_PULSE);
  modport slave  (input SW_RAW, BTN_RAW, output SWT, Enter, ENTER_PULSE);
endinterface

// File: rtl/xidoo_input_cond.sv
// Synchronises and debounces the switch bank and Enter button feeding the core.
// SWT is frozen while the button FSM is busy so the core reads a coherent byte on Enter.
module xidoo_input_cond #(
  parameter int unsigned DEB_CYCLES = 50000
) (
  input logic                  CLK,
  input logic                  RST,
  xidoo_input_cond_if.slave    bus
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       sw_meta_q, sw_meta_d;
  logic [7:0]       sw_sync_q, sw_sync_d;
  logic             btn_meta_q, btn_meta_d;
  logic             btn_sync_q, btn_sync_d;
  logic [7:0]       sw_cand_q, sw_cand_d;
  logic [CNT_W-1:0] sw_cnt_q, sw_cnt_d;
  logic [7:0]       swt_q, swt_d;
  logic [CNT_W-1:0] btn_cnt_q, btn_cnt_d;
  logic             enter_q, enter_d;
  logic             pulse_q, pulse_d;

  // Two-flop synchronisers on all nine raw bits
  always_comb begin
    sw_meta_d  = bus.SW_RAW;
    sw_sync_d  = sw_meta_q;
    btn_meta_d = bus.BTN_RAW;
    btn_sync_d = btn_meta_q;
  end

  // Switch candidate tracking; publish only when qualified and the button FSM is idle
  always_comb begin
    sw_cand_d = sw_cand_q;
    sw_cnt_d  = sw_cnt_q;
    swt_d     = swt_q;
    if (sw_sync_q != sw_cand_q) begin
      sw_cand_d = sw_sync_q;
      sw_cnt_d  = '0;
    end else begin
      if (sw_cnt_q != CNT_MAX) begin
        sw_cnt_d = sw_cnt_q + CNT_W'(1);
      end
      if ((sw_cnt_q == CNT_MAX) && (state_q == IDLE)) begin
        swt_d = sw_cand_q;
      end
    end
  end

  // Button debounce FSM
  always_comb begin
    state_d   = state_q;
    btn_cnt_d = btn_cnt_q;
    enter_d   = enter_q;
    pulse_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (btn_sync_q) begin
          state_d   = PRESS_WAIT;
          btn_cnt_d = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btn_sync_q) begin
          state_d = IDLE;
        end else if (btn_cnt_q == CNT_MAX) begin
          state_d = PRESSED;
          enter_d = 1'b1;
          pulse_d = 1'b1;
        end else begin
          btn_cnt_d = btn_cnt_q + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!btn_sync_q) begin
          state_d   = RELEASE_WAIT;
          btn_cnt_d = '0;
        end
      end
      RELEASE_WAIT: begin
        if (btn_sync_q) begin
          state_d = PRESSED;
        end else if (btn_cnt_q == CNT_MAX) begin
          state_d = IDLE;
          enter_d = 1'b0;
        end else begin
          btn_cnt_d = btn_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
      btn_meta_q <= 1'b0;
      btn_sync_q <= 1'b0;
      sw_cand_q  <= '0;
      sw_cnt_q   <= '0;
      swt_q      <= '0;
      btn_cnt_q  <= '0;
      enter_q    <= 1'b0;
      pulse_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sw_meta_q  <= sw_meta_d;
      sw_sync_q  <= sw_sync_d;
      btn_meta_q <= btn_meta_d;
      btn_sync_q <= btn_sync_d;
      sw_cand_q  <= sw_cand_d;
      sw_cnt_q   <= sw_cnt_d;
      swt_q      <= swt_d;
      btn_cnt_q  <= btn_cnt_d;
      enter_q    <= enter_d;
      pulse_q    <= pulse_d;
    end
  end

  assign bus.SWT         = swt_q;
  assign bus.Enter       = enter_q;
  assign bus.ENTER_PULSE = pulse_q;

endmodule

// File: tb/tb_xidoo_input_cond.sv
// Self-checking bench for xidoo_input_cond with DEB_CYCLES=4 (qualification lands on edge 7).
module tb_xidoo_input_cond;

  logic CLK;
  logic RST;
  xidoo_input_cond_if dut_if ();

  xidoo_input_cond #(.DEB_CYCLES(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (dut_if.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;
  int pulse_total = 0;

  typedef struct {
    logic [7:0] sw;
    logic       btn;
    int         edges;
    logic [7:0] exp_swt;
    logic       exp_en;
    logic       exp_pulse;
  } vec_t;

  typedef struct {
    int         idx;
    logic [7:0] swt;
    logic       en;
    logic       pulse;
  } exp_t;

  vec_t vecs[8];
  exp_t sb[$];

  always @(negedge CLK) begin
    if (dut_if.ENTER_PULSE === 1'b1) pulse_total++;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Advance n rising edges and settle 1 ns past the last one
  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  initial begin
    exp_t e;
    logic bad;

    // {sw, btn, edges, exp SWT, exp Enter, exp pulse}
    vecs[0] = '{8'hA5, 1'b0, 6,  8'h00, 1'b0, 1'b0};
    vecs[1] = '{8'hA5, 1'b0, 1,  8'hA5, 1'b0, 1'b0};
    vecs[2] = '{8'hA5, 1'b1, 6,  8'hA5, 1'b0, 1'b0};
    vecs[3] = '{8'hA5, 1'b1, 1,  8'hA5, 1'b1, 1'b1};
    vecs[4] = '{8'hA5, 1'b1, 1,  8'hA5, 1'b1, 1'b0};
    vecs[5] = '{8'hA5, 1'b1, 12, 8'hA5, 1'b1, 1'b0};
    vecs[6] = '{8'hA5, 1'b0, 6,  8'hA5, 1'b1, 1'b0};
    vecs[7] = '{8'hA5, 1'b0, 1,  8'hA5, 1'b0, 1'b0};

    RST = 1'b0;
    dut_if.SW_RAW  = 8'h00;
    dut_if.BTN_RAW = 1'b0;
    #3;
    chk("reset_swt", 32'(dut_if.SWT), 32'h00);
    chk("reset_enter", 32'(dut_if.Enter), 32'h0);
    chk("reset_pulse", 32'(dut_if.ENTER_PULSE), 32'h0);
    step(3);
    RST = 1'b1;
    step(3);
    chk("idle_swt", 32'(dut_if.SWT), 32'h00);

    // Switch qualification and a clean press/release
    for (int i = 0; i < 8; i++) begin
      dut_if.SW_RAW  = vecs[i].sw;
      dut_if.BTN_RAW = vecs[i].btn;
      sb.push_back('{i, vecs[i].exp_swt, vecs[i].exp_en, vecs[i].exp_pulse});
      step(vecs[i].edges);
      e = sb.pop_front();
      chk($sformatf("vec%0d_swt", e.idx), 32'(dut_if.SWT), 32'(e.swt));
      chk($sformatf("vec%0d_enter", e.idx), 32'(dut_if.Enter), 32'(e.en));
      chk($sformatf("vec%0d_pulse", e.idx), 32'(dut_if.ENTER_PULSE), 32'(e.pulse));
    end
    step(8);
    chk("clean_press_pulses", 32'(pulse_total), 32'd1);

    // Switch bounce must never leak an intermediate value
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      dut_if.SW_RAW = (i % 2 == 0) ? 8'h0F : 8'hF0;
      for (int k = 0; k < 2; k++) begin
        step(1);
        if (dut_if.SWT !== 8'hA5) bad = 1'b1;
      end
    end
    chk("bounce_no_leak", 32'(bad), 32'h0);
    dut_if.SW_RAW = 8'h3C;
    step(6);
    chk("bounce_settle_e6", 32'(dut_if.SWT), 32'hA5);
    step(1);
    chk("bounce_settle_e7", 32'(dut_if.SWT), 32'h3C);

    // Short button glitch is rejected
    dut_if.BTN_RAW = 1'b1;
    step(2);
    dut_if.BTN_RAW = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (dut_if.Enter !== 1'b0) bad = 1'b1;
    end
    chk("glitch_enter", 32'(bad), 32'h0);
    chk("glitch_pulses", 32'(pulse_total), 32'd1);

    // Release bounce while pressed keeps Enter high with no extra pulse
    dut_if.BTN_RAW = 1'b1;
    step(7);
    chk("rb_enter_rise", 32'(dut_if.Enter), 32'h1);
    dut_if.BTN_RAW = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 14; i++) begin
      if (i == 2) dut_if.BTN_RAW = 1'b1;
      step(1);
      if (dut_if.Enter !== 1'b1) bad = 1'b1;
    end
    chk("rb_enter_held", 32'(bad), 32'h0);
    chk("rb_pulses", 32'(pulse_total), 32'd2);
    dut_if.BTN_RAW = 1'b0;
    step(6);
    chk("rb_release_e6", 32'(dut_if.Enter), 32'h1);
    step(1);
    chk("rb_release_e7", 32'(dut_if.Enter), 32'h0);

    // Freeze: SWT holds while pressed, new byte lands one edge after Enter falls
    dut_if.SW_RAW = 8'h11;
    step(7);
    chk("frz_swt_11", 32'(dut_if.SWT), 32'h11);
    dut_if.BTN_RAW = 1'b1;
    step(7);
    chk("frz_enter", 32'(dut_if.Enter), 32'h1);
    dut_if.SW_RAW = 8'h22;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (dut_if.SWT !== 8'h11) bad = 1'b1;
    end
    chk("frz_hold", 32'(bad), 32'h0);
    dut_if.BTN_RAW = 1'b0;
    step(7);
    chk("frz_enter_fall", 32'(dut_if.Enter), 32'h0);
    chk("frz_swt_still", 32'(dut_if.SWT), 32'h11);
    step(1);
    chk("frz_swt_22", 32'(dut_if.SWT), 32'h22);
    chk("frz_pulses", 32'(pulse_total), 32'd3);

    // Asynchronous reset mid press-qualification
    dut_if.SW_RAW = 8'h5A;
    step(7);
    chk("rst_pre_swt", 32'(dut_if.SWT), 32'h5A);
    dut_if.BTN_RAW = 1'b1;
    step(4);
    #2;
    RST = 1'b0;
    #1;
    chk("rst_async_swt", 32'(dut_if.SWT), 32'h00);
    chk("rst_async_enter", 32'(dut_if.Enter), 32'h0);
    chk("rst_async_pulse", 32'(dut_if.ENTER_PULSE), 32'h0);
    step(1);
    RST = 1'b1;
    step(6);
    chk("rst_restart_e6", 32'(dut_if.Enter), 32'h0);
    step(1);
    chk("rst_restart_e7", 32'(dut_if.Enter), 32'h1);
    chk("rst_restart_pulse", 32'(dut_if.ENTER_PULSE), 32'h1);
    chk("rst_swt_frozen", 32'(dut_if.SWT), 32'h00);
    dut_if.BTN_RAW = 1'b0;
    step(7);
    chk("rst_rel_enter", 32'(dut_if.Enter), 32'h0);
    chk("rst_rel_swt", 32'(dut_if.SWT), 32'h00);
    step(1);
    chk("rst_rel_swt_5a", 32'(dut_if.SWT), 32'h5A);
    step(2);
    chk("rst_pulses", 32'(pulse_total), 32'd4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
